// File: rtl/softmax_max_sub.sv
// Streaming max-subtract stage: buffers one vector, tracks its maximum,
// then replays every element as (max - x) to the exponent stage.
module softmax_max_sub #(
    parameter int DATA_W = 7,
    parameter int LANES  = 4,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*DATA_W-1:0]   out_data,
    output logic                      out_last,
    output logic [DATA_W-1:0]         vec_max,
    output logic                      ovf
);

    localparam int VW = LANES * DATA_W;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        LOAD,
        DRAIN
    } state_t;

    state_t            state;
    logic [CW-1:0]     wr_cnt;
    logic [CW-1:0]     rd_cnt;
    logic [CW-1:0]     len;
    logic [DATA_W-1:0] max_q;
    logic              ovf_q;
    logic [VW-1:0]     mem [DEPTH];

    logic              in_hs;
    logic              out_hs;
    logic              cap_full;
    logic              rd_last;
    logic [DATA_W-1:0] beat_max;
    logic [DATA_W-1:0] next_max;
    logic [VW-1:0]     rd_word;
    logic [VW-1:0]     diff_word;

    // Handshakes and phase-derived status; in_ready sees only state and rst.
    assign in_ready  = (state == LOAD) && !rst;
    assign out_valid = (state == DRAIN);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign cap_full  = (wr_cnt == CW'(DEPTH - 1));
    assign rd_last   = (rd_cnt == len - CW'(1));
    assign ovf       = ovf_q;

    // Largest lane of the incoming beat.
    always_comb begin
        beat_max = in_data[0 +: DATA_W];
        for (int i = 1; i < LANES; i++) begin
            if (in_data[i*DATA_W +: DATA_W] > beat_max) begin
                beat_max = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Running maximum; the first beat of a vector ignores the old value.
    always_comb begin
        next_max = max_q;
        if (wr_cnt == '0 || beat_max > max_q) begin
            next_max = beat_max;
        end
    end

    // Per-lane magnitude; max dominates every element so no borrow occurs.
    always_comb begin
        rd_word   = mem[rd_cnt[AW-1:0]];
        diff_word = '0;
        for (int i = 0; i < LANES; i++) begin
            diff_word[i*DATA_W +: DATA_W] =
                max_q - rd_word[i*DATA_W +: DATA_W];
        end
    end

    // Outputs read only registers and are zeroed outside DRAIN.
    always_comb begin
        out_data = '0;
        out_last = 1'b0;
        vec_max  = '0;
        if (out_valid) begin
            out_data = diff_word;
            out_last = rd_last;
            vec_max  = max_q;
        end
    end

    // Element buffer; contents beyond len are never read.
    always_ff @(posedge clk) begin
        if (in_hs) begin
            mem[wr_cnt[AW-1:0]] <= in_data;
        end
    end

    // LOAD/DRAIN sequencing, counters, running max and overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= LOAD;
            wr_cnt <= '0;
            rd_cnt <= '0;
            len    <= '0;
            max_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (in_hs) begin
                        max_q <= next_max;
                        if (in_last || cap_full) begin
                            len    <= wr_cnt + CW'(1);
                            wr_cnt <= '0;
                            rd_cnt <= '0;
                            ovf_q  <= !in_last;
                            state  <= DRAIN;
                        end else begin
                            wr_cnt <= wr_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_hs) begin
                        if (rd_last) begin
                            rd_cnt <= '0;
                            wr_cnt <= '0;
                            state  <= LOAD;
                        end else begin
                            rd_cnt <= rd_cnt + CW'(1);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
